// File: rtl/pong_sfx_arbiter.sv
// pong_sfx_arbiter
// Shares one square-wave speaker between four game sound effects. Requests
// are latched as pending flags and served one at a time in fixed priority
// order (over > score > paddle > wall), with a silent gap between tones. A
// strictly higher-priority request cuts the current tone short. Game-over
// plays as two back-to-back notes.
//
// Ports
//   clk_0     : system clock (25.175 MHz)
//   rst       : asynchronous active-low reset
//   ev_wall   : wall-bounce request pulse
//   ev_paddle : paddle-hit request pulse
//   ev_score  : point-scored request pulse
//   ev_over   : game-over request pulse
//   mute      : 1 silences the buzzer without affecting sequencing
//   buzzer    : square-wave speaker drive
//   busy      : 1 while a tone or the inter-tone gap is in progress
//   tone_id   : 0 none, 1 wall, 2 paddle, 3 score, 4 over1, 5 over2
module pong_sfx_arbiter #(
  parameter int HP_WALL   = 100_000,
  parameter int HP_PADDLE = 50_000,
  parameter int HP_SCORE  = 25_000,
  parameter int HP_OVER1  = 40_000,
  parameter int HP_OVER2  = 80_000,
  parameter int DUR_SHORT = 1_258_750,
  parameter int DUR_LONG  = 5_035_000,
  parameter int GAP       = 251_750
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic       ev_wall,
  input  logic       ev_paddle,
  input  logic       ev_score,
  input  logic       ev_over,
  input  logic       mute,
  output logic       buzzer,
  output logic       busy,
  output logic [2:0] tone_id
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int HP_MAX  = max2(max2(max2(HP_WALL, HP_PADDLE), max2(HP_SCORE, HP_OVER1)), HP_OVER2);
  localparam int DUR_MAX = max2(DUR_SHORT, DUR_LONG);
  localparam int HP_W    = $clog2(HP_MAX + 1);
  localparam int DUR_W   = $clog2(DUR_MAX + 1);
  localparam int GAP_W   = $clog2(GAP + 1);

  localparam logic [HP_W-1:0]  HPL_WALL   = HP_W'(HP_WALL - 1);
  localparam logic [HP_W-1:0]  HPL_PADDLE = HP_W'(HP_PADDLE - 1);
  localparam logic [HP_W-1:0]  HPL_SCORE  = HP_W'(HP_SCORE - 1);
  localparam logic [HP_W-1:0]  HPL_OVER1  = HP_W'(HP_OVER1 - 1);
  localparam logic [HP_W-1:0]  HPL_OVER2  = HP_W'(HP_OVER2 - 1);
  localparam logic [DUR_W-1:0] DURL_SHORT = DUR_W'(DUR_SHORT - 1);
  localparam logic [DUR_W-1:0] DURL_LONG  = DUR_W'(DUR_LONG - 1);
  localparam logic [GAP_W-1:0] GAPL       = GAP_W'(GAP - 1);

  localparam logic [2:0] T_NONE   = 3'd0;
  localparam logic [2:0] T_WALL   = 3'd1;
  localparam logic [2:0] T_PADDLE = 3'd2;
  localparam logic [2:0] T_SCORE  = 3'd3;
  localparam logic [2:0] T_OVER1  = 3'd4;
  localparam logic [2:0] T_OVER2  = 3'd5;

  typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_GAP} state_t;

  state_t            state, state_n;
  logic [3:0]        pend, pend_n, pend_clr;
  logic [2:0]        tone_q, tone_n;
  logic [DUR_W-1:0]  dur_cnt, dur_n;
  logic [HP_W-1:0]   hp_cnt, hp_n;
  logic [GAP_W-1:0]  gap_cnt, gap_n;
  logic              buzz_q, buzz_n;
  logic              launch;
  logic [2:0]        win;
  logic [HP_W-1:0]   hp_lim;
  logic [DUR_W-1:0]  dur_lim;

  // Highest-priority pending request, expressed as the tone it would start.
  // The returned code doubles as its priority rank (1 lowest .. 4 highest).
  function automatic logic [2:0] top_req(input logic [3:0] p);
    if (p[3])      return T_OVER1;
    else if (p[2]) return T_SCORE;
    else if (p[1]) return T_PADDLE;
    else if (p[0]) return T_WALL;
    else           return T_NONE;
  endfunction

  // Both game-over notes rank as "over" so nothing re-triggers over1 mid-tune.
  function automatic logic [2:0] tone_prio(input logic [2:0] t);
    return (t == T_OVER2) ? T_OVER1 : t;
  endfunction

  function automatic logic [3:0] req_bit(input logic [2:0] t);
    case (t)
      T_WALL:   return 4'b0001;
      T_PADDLE: return 4'b0010;
      T_SCORE:  return 4'b0100;
      T_OVER1:  return 4'b1000;
      default:  return 4'b0000;
    endcase
  endfunction

  always_comb begin
    case (tone_q)
      T_WALL:   hp_lim = HPL_WALL;
      T_PADDLE: hp_lim = HPL_PADDLE;
      T_SCORE:  hp_lim = HPL_SCORE;
      T_OVER1:  hp_lim = HPL_OVER1;
      default:  hp_lim = HPL_OVER2;
    endcase
    dur_lim = (tone_q == T_WALL || tone_q == T_PADDLE) ? DURL_SHORT : DURL_LONG;
  end

  always_comb begin
    state_n  = state;
    tone_n   = tone_q;
    dur_n    = dur_cnt;
    hp_n     = hp_cnt;
    gap_n    = gap_cnt;
    buzz_n   = buzz_q;
    pend_clr = 4'b0000;
    launch   = 1'b0;
    win      = top_req(pend);

    case (state)
      ST_IDLE: begin
        if (win != T_NONE) launch = 1'b1;
      end
      ST_PLAY: begin
        if (win > tone_prio(tone_q)) begin
          launch = 1'b1;
        end else if (dur_cnt == dur_lim) begin
          dur_n  = '0;
          hp_n   = '0;
          buzz_n = 1'b0;
          if (tone_q == T_OVER1) begin
            tone_n = T_OVER2;
          end else begin
            state_n = ST_GAP;
            gap_n   = '0;
          end
        end else begin
          dur_n = dur_cnt + 1'b1;
          if (hp_cnt == hp_lim) begin
            hp_n   = '0;
            buzz_n = ~buzz_q;
          end else begin
            hp_n = hp_cnt + 1'b1;
          end
        end
      end
      ST_GAP: begin
        // The gap always runs to completion; pending requests only
        // decide what follows it.
        if (gap_cnt == GAPL) begin
          if (win != T_NONE) begin
            launch = 1'b1;
          end else begin
            state_n = ST_IDLE;
            tone_n  = T_NONE;
          end
        end else begin
          gap_n = gap_cnt + 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        tone_n  = T_NONE;
      end
    endcase

    if (launch) begin
      state_n  = ST_PLAY;
      tone_n   = win;
      pend_clr = req_bit(win);
      dur_n    = '0;
      hp_n     = '0;
      buzz_n   = 1'b0;
    end

    // A new pulse on the edge its flag is consumed still counts as a request.
    pend_n = (pend & ~pend_clr) | {ev_over, ev_score, ev_paddle, ev_wall};
  end

  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      pend    <= '0;
      tone_q  <= T_NONE;
      dur_cnt <= '0;
      hp_cnt  <= '0;
      gap_cnt <= '0;
      buzz_q  <= 1'b0;
    end else begin
      state   <= state_n;
      pend    <= pend_n;
      tone_q  <= tone_n;
      dur_cnt <= dur_n;
      hp_cnt  <= hp_n;
      gap_cnt <= gap_n;
      buzz_q  <= buzz_n;
    end
  end

  assign buzzer  = buzz_q & ~mute;
  assign busy    = (state != ST_IDLE);
  assign tone_id = tone_q;

endmodule

// File: tb/tb_pong_sfx_arbiter.sv
// Directed testbench for pong_sfx_arbiter with short tone/gap parameters.
// Expected outputs come from a per-test list of segments (tone or gap, end
// cycle) written by hand from the required timing; cycle k is the k-th
// rising edge after the edge that sampled the launching request.
module tb_pong_sfx_arbiter;

  localparam int HPW = 2, HPP = 3, HPS = 4, HPO1 = 5, HPO2 = 6;

  logic       clk_0 = 1'b0;
  logic       rst = 1'b0;
  logic       ev_wall = 1'b0, ev_paddle = 1'b0, ev_score = 1'b0, ev_over = 1'b0;
  logic       mute = 1'b0;
  logic       buzzer, busy;
  logic [2:0] tone_id;

  int n_pass = 0;
  int n_total = 0;

  int seg_end[8];
  int seg_tone[8];
  int nseg;

  logic       e_busy, e_buzz, e_tone_chk;
  logic [2:0] e_tone;

  always #5 clk_0 = ~clk_0;

  pong_sfx_arbiter #(
    .HP_WALL(HPW), .HP_PADDLE(HPP), .HP_SCORE(HPS), .HP_OVER1(HPO1), .HP_OVER2(HPO2),
    .DUR_SHORT(20), .DUR_LONG(40), .GAP(8)
  ) dut (
    .clk_0(clk_0), .rst(rst),
    .ev_wall(ev_wall), .ev_paddle(ev_paddle), .ev_score(ev_score), .ev_over(ev_over),
    .mute(mute), .buzzer(buzzer), .busy(busy), .tone_id(tone_id)
  );

  function automatic int hp_of(input int t);
    case (t)
      1: return HPW;
      2: return HPP;
      3: return HPS;
      4: return HPO1;
      5: return HPO2;
      default: return 1;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk_0);
    #1;
  endtask

  // Expected outputs at cycle k from the segment list. Tone code 0 = gap.
  // A tone starts with buzzer low and toggles every hp cycles.
  task automatic model(input int k);
    int start;
    start = 1;
    e_busy = 1'b0; e_buzz = 1'b0; e_tone = 3'd0; e_tone_chk = 1'b1;
    for (int i = 0; i < nseg; i++) begin
      if (k >= start && k <= seg_end[i]) begin
        e_busy = 1'b1;
        if (seg_tone[i] == 0) begin
          e_tone_chk = 1'b0;
        end else begin
          e_tone = 3'(seg_tone[i]);
          e_buzz = (((k - start) / hp_of(seg_tone[i])) % 2) == 1;
        end
      end
      start = seg_end[i] + 1;
    end
  endtask

  task automatic fire(input logic w, input logic p, input logic s, input logic o);
    ev_wall = w; ev_paddle = p; ev_score = s; ev_over = o;
    tick;
    ev_wall = 1'b0; ev_paddle = 1'b0; ev_score = 1'b0; ev_over = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    ev_wall = 1'b1;
    tick;
    tick;
    ev_wall = 1'b0;
    n_total++;
    if ({busy, tone_id, buzzer} !== 5'b0)
      $display("FAIL reset_hold busy/tone_id/buzzer=%b/%0d/%b expected 0/0/0", busy, tone_id, buzzer);
    else n_pass++;
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick;
      n_total++;
      if ({busy, tone_id, buzzer} !== 5'b0)
        $display("FAIL reset_release k=%0d busy/tone_id/buzzer=%b/%0d/%b expected 0/0/0", k, busy, tone_id, buzzer);
      else n_pass++;
    end
  endtask

  task automatic test_paddle;
    nseg = 2;
    seg_end[0] = 20; seg_tone[0] = 2;
    seg_end[1] = 28; seg_tone[1] = 0;
    fire(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 31; k++) begin
      tick;
      model(k);
      n_total++;
      if ({busy, buzzer} !== {e_busy, e_buzz})
        $display("FAIL paddle k=%0d busy/buzzer=%b%b expected %b%b", k, busy, buzzer, e_busy, e_buzz);
      else n_pass++;
      if (e_tone_chk) begin
        n_total++;
        if (tone_id !== e_tone) $display("FAIL paddle_tone k=%0d tone_id=%0d expected %0d", k, tone_id, e_tone);
        else n_pass++;
      end
    end
  endtask

  task automatic test_simultaneous;
    nseg = 6;
    seg_end[0] = 40;  seg_tone[0] = 3;
    seg_end[1] = 48;  seg_tone[1] = 0;
    seg_end[2] = 68;  seg_tone[2] = 2;
    seg_end[3] = 76;  seg_tone[3] = 0;
    seg_end[4] = 96;  seg_tone[4] = 1;
    seg_end[5] = 104; seg_tone[5] = 0;
    fire(1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 107; k++) begin
      tick;
      model(k);
      n_total++;
      if ({busy, buzzer} !== {e_busy, e_buzz})
        $display("FAIL simultaneous k=%0d busy/buzzer=%b%b expected %b%b", k, busy, buzzer, e_busy, e_buzz);
      else n_pass++;
      if (e_tone_chk) begin
        n_total++;
        if (tone_id !== e_tone) $display("FAIL simultaneous_tone k=%0d tone_id=%0d expected %0d", k, tone_id, e_tone);
        else n_pass++;
      end
    end
  endtask

  task automatic test_preempt;
    nseg = 3;
    seg_end[0] = 5;  seg_tone[0] = 1;
    seg_end[1] = 45; seg_tone[1] = 3;
    seg_end[2] = 53; seg_tone[2] = 0;
    fire(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 57; k++) begin
      ev_score = (k == 5);
      tick;
      ev_score = 1'b0;
      model(k);
      n_total++;
      if ({busy, buzzer} !== {e_busy, e_buzz})
        $display("FAIL preempt k=%0d busy/buzzer=%b%b expected %b%b", k, busy, buzzer, e_busy, e_buzz);
      else n_pass++;
      if (e_tone_chk) begin
        n_total++;
        if (tone_id !== e_tone) $display("FAIL preempt_tone k=%0d tone_id=%0d expected %0d", k, tone_id, e_tone);
        else n_pass++;
      end
    end
  endtask

  task automatic test_over;
    nseg = 3;
    seg_end[0] = 40; seg_tone[0] = 4;
    seg_end[1] = 80; seg_tone[1] = 5;
    seg_end[2] = 88; seg_tone[2] = 0;
    fire(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 91; k++) begin
      tick;
      model(k);
      n_total++;
      if ({busy, buzzer} !== {e_busy, e_buzz})
        $display("FAIL over k=%0d busy/buzzer=%b%b expected %b%b", k, busy, buzzer, e_busy, e_buzz);
      else n_pass++;
      if (e_tone_chk) begin
        n_total++;
        if (tone_id !== e_tone) $display("FAIL over_tone k=%0d tone_id=%0d expected %0d", k, tone_id, e_tone);
        else n_pass++;
      end
    end
  endtask

  task automatic test_mute;
    nseg = 2;
    seg_end[0] = 40; seg_tone[0] = 3;
    seg_end[1] = 48; seg_tone[1] = 0;
    fire(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 51; k++) begin
      mute = (k >= 10 && k <= 30);
      tick;
      model(k);
      if (mute) e_buzz = 1'b0;
      n_total++;
      if ({busy, buzzer} !== {e_busy, e_buzz})
        $display("FAIL mute k=%0d busy/buzzer=%b%b expected %b%b", k, busy, buzzer, e_busy, e_buzz);
      else n_pass++;
      if (e_tone_chk) begin
        n_total++;
        if (tone_id !== e_tone) $display("FAIL mute_tone k=%0d tone_id=%0d expected %0d", k, tone_id, e_tone);
        else n_pass++;
      end
    end
    mute = 1'b0;
  endtask

  // Wall re-requested twice while playing (one replay), and game-over
  // requested mid-gap: the gap still runs its full length, then over
  // plays ahead of the waiting wall replay.
  task automatic test_replay_gap;
    nseg = 7;
    seg_end[0] = 20;  seg_tone[0] = 1;
    seg_end[1] = 28;  seg_tone[1] = 0;
    seg_end[2] = 68;  seg_tone[2] = 4;
    seg_end[3] = 108; seg_tone[3] = 5;
    seg_end[4] = 116; seg_tone[4] = 0;
    seg_end[5] = 136; seg_tone[5] = 1;
    seg_end[6] = 144; seg_tone[6] = 0;
    fire(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 147; k++) begin
      ev_wall = (k == 3 || k == 5);
      ev_over = (k == 23);
      tick;
      ev_wall = 1'b0;
      ev_over = 1'b0;
      model(k);
      n_total++;
      if ({busy, buzzer} !== {e_busy, e_buzz})
        $display("FAIL replay_gap k=%0d busy/buzzer=%b%b expected %b%b", k, busy, buzzer, e_busy, e_buzz);
      else n_pass++;
      if (e_tone_chk) begin
        n_total++;
        if (tone_id !== e_tone) $display("FAIL replay_gap_tone k=%0d tone_id=%0d expected %0d", k, tone_id, e_tone);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid;
    nseg = 1;
    seg_end[0] = 40; seg_tone[0] = 3;
    fire(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      ev_wall = (k == 3);
      tick;
      ev_wall = 1'b0;
      model(k);
      n_total++;
      if ({busy, tone_id, buzzer} !== {e_busy, e_tone, e_buzz})
        $display("FAIL reset_mid_pre k=%0d busy/tone_id/buzzer=%b/%0d/%b expected %b/%0d/%b",
                 k, busy, tone_id, buzzer, e_busy, e_tone, e_buzz);
      else n_pass++;
    end
    rst = 1'b0;
    #1;
    n_total++;
    if ({busy, tone_id, buzzer} !== 5'b0)
      $display("FAIL reset_mid_async busy/tone_id/buzzer=%b/%0d/%b expected 0/0/0", busy, tone_id, buzzer);
    else n_pass++;
    tick;
    tick;
    rst = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick;
      n_total++;
      if ({busy, tone_id, buzzer} !== 5'b0)
        $display("FAIL reset_mid_after k=%0d busy/tone_id/buzzer=%b/%0d/%b expected 0/0/0", k, busy, tone_id, buzzer);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset;
    test_paddle;
    test_simultaneous;
    test_preempt;
    test_over;
    test_mute;
    test_replay_gap;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
